hilo_muldiv_unit: RTL and testbench

- Execute-stage consumer of the 6-bit alucontrol codes for MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO.
- Owns the architectural HI/LO registers and runs multi-cycle multiply and divide.
- Raises a stall to the hazard unit while an operation is in flight.
- Sits beside the single-cycle ALU in the datapath E stage.

---
 rtl/hilo_muldiv_unit_pkg.sv | 42 ++++
 rtl/hilo_muldiv_unit_div_radix2.sv | 67 ++++++
 rtl/hilo_muldiv_unit.sv | 139 +++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: ALU control codes,
// FSM states and arithmetic helpers.
package hilo_muldiv_unit_pkg;

  localparam logic [5:0] MFHI_CONTROL  = 6'b010000;
  localparam logic [5:0] MTHI_CONTROL  = 6'b010001;
  localparam logic [5:0] MFLO_CONTROL  = 6'b010010;
  localparam logic [5:0] MTLO_CONTROL  = 6'b010011;
  localparam logic [5:0] MULT_CONTROL  = 6'b011000;
  localparam logic [5:0] MULTU_CONTROL = 6'b011001;
  localparam logic [5:0] DIV_CONTROL   = 6'b011010;
  localparam logic [5:0] DIVU_CONTROL  = 6'b011011;

  localparam int MUL_LAT_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_muldiv(input logic [5:0] op);
    return (op == MULT_CONTROL) || (op == MULTU_CONTROL) ||
           (op == DIV_CONTROL)  || (op == DIVU_CONTROL);
  endfunction

  // Sign-extend only for signed ops so one 64-bit multiply covers both.
  function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y,
                                        input logic sgn);
    logic [63:0] xe;
    logic [63:0] ye;
    xe = {{32{sgn & x[31]}}, x};
    ye = {{32{sgn & y[31]}}, y};
    return xe * ye;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] x, input logic sgn);
    return (sgn & x[31]) ? (32'd0 - x) : x;
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_div_radix2.sv
// 32-cycle restoring unsigned divider. quotient/remainder present the result of
// the step being taken this cycle, so they are final while done is high.
module hilo_muldiv_unit_div_radix2 (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        cancel,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        busy_r;
  logic [4:0]  cnt_r;
  logic [31:0] quo_r;
  logic [31:0] rem_r;
  logic [31:0] dvs_r;
  logic [33:0] trial_s;
  logic [31:0] quo_next_s;
  logic [31:0] rem_next_s;

  // One restoring step: shift in the next dividend bit and try to subtract.
  always_comb begin
    trial_s = {1'b0, rem_r, quo_r[31]} - {2'b00, dvs_r};
    if (trial_s[33]) begin
      rem_next_s = {rem_r[30:0], quo_r[31]};
      quo_next_s = {quo_r[30:0], 1'b0};
    end else begin
      rem_next_s = trial_s[31:0];
      quo_next_s = {quo_r[30:0], 1'b1};
    end
  end

  // Iteration registers; the dividend shifts out as quotient bits shift in.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_r <= 1'b0;
      cnt_r  <= 5'd0;
      quo_r  <= 32'd0;
      rem_r  <= 32'd0;
      dvs_r  <= 32'd0;
    end else if (cancel) begin
      busy_r <= 1'b0;
      cnt_r  <= 5'd0;
    end else if (start) begin
      busy_r <= 1'b1;
      cnt_r  <= 5'd0;
      quo_r  <= dividend;
      rem_r  <= 32'd0;
      dvs_r  <= divisor;
    end else if (busy_r) begin
      quo_r  <= quo_next_s;
      rem_r  <= rem_next_s;
      cnt_r  <= cnt_r + 5'd1;
      busy_r <= (cnt_r != 5'd31);
    end
  end

  assign busy      = busy_r;
  assign done      = busy_r && (cnt_r == 5'd31);
  assign quotient  = quo_next_s;
  assign remainder = rem_next_s;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// E-stage HI/LO unit: multi-cycle MULT/MULTU/DIV/DIVU with stall to the hazard
// unit, plus MTHI/MTLO writes and MFHI/MFLO read mux.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int MUL_LAT  = MUL_LAT_DEFAULT,
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  alucontrol,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] mf_data_o
);

  state_t      state_r;
  logic [4:0]  cnt_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        done_r;
  logic [63:0] prod_r;
  logic        q_neg_r;
  logic        r_neg_r;

  logic        accept_s;
  logic        is_mul_s;
  logic        sgn_s;
  logic        div_busy_s;
  logic        div_done_s;
  logic [31:0] div_q_s;
  logic [31:0] div_r_s;

  assign accept_s = (state_r == ST_IDLE) && start && !flush && is_muldiv(alucontrol);
  assign is_mul_s = (alucontrol == MULT_CONTROL) || (alucontrol == MULTU_CONTROL);
  assign sgn_s    = (alucontrol == MULT_CONTROL) || (alucontrol == DIV_CONTROL);
  assign stall_o  = accept_s || (state_r == ST_MUL) || (state_r == ST_DIV);

  hilo_muldiv_unit_div_radix2 u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (accept_s && !is_mul_s),
    .cancel    (flush),
    .dividend  (abs32(a, sgn_s)),
    .divisor   (abs32(b, sgn_s)),
    .busy      (div_busy_s),
    .done      (div_done_s),
    .quotient  (div_q_s),
    .remainder (div_r_s)
  );

  // Control FSM, HI/LO architectural state and the registered product.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      cnt_r   <= 5'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      done_r  <= 1'b0;
      prod_r  <= 64'd0;
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (flush) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (accept_s && is_mul_s) begin
            prod_r  <= mul64(a, b, sgn_s);
            cnt_r   <= 5'(MUL_LAT - 1);
            state_r <= ST_MUL;
          end else if (accept_s) begin
            q_neg_r <= sgn_s & (a[31] ^ b[31]);
            r_neg_r <= sgn_s & a[31];
            cnt_r   <= 5'(DIV_ITER - 1);
            state_r <= ST_DIV;
          end else if (start && (alucontrol == MTHI_CONTROL)) begin
            hi_r <= a;
          end else if (start && (alucontrol == MTLO_CONTROL)) begin
            lo_r <= a;
          end
        end
        ST_MUL: begin
          if (cnt_r == 5'd0) begin
            hi_r    <= prod_r[63:32];
            lo_r    <= prod_r[31:0];
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - 5'd1;
          end
        end
        ST_DIV: begin
          if ((cnt_r == 5'd0) && div_done_s) begin
            hi_r    <= r_neg_r ? (32'd0 - div_r_s) : div_r_s;
            lo_r    <= q_neg_r ? (32'd0 - div_q_s) : div_q_s;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else if ((cnt_r == 5'd0) || !div_busy_s) begin
            // Divider lost sync with the counter: drop the op rather than hang.
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - 5'd1;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // MFHI/MFLO read port for the E-stage result mux.
  always_comb begin
    case (alucontrol)
      MFHI_CONTROL: mf_data_o = hi_r;
      MFLO_CONTROL: mf_data_o = lo_r;
      default:      mf_data_o = 32'd0;
    endcase
  end

  assign done_o = done_r;
  assign hi_o   = hi_r;
  assign lo_o   = lo_r;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench: cycle-level reference model plus directed literal checks
// and randomized traffic for hilo_muldiv_unit.
module tb_hilo_muldiv_unit;
  import hilo_muldiv_unit_pkg::*;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [5:0]  alucontrol = 6'd0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        stall_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] mf_data_o;

  int n_pass = 0;
  int n_total = 0;
  logic chk_en = 1'b0;

  hilo_muldiv_unit #(.MUL_LAT(MUL_LAT), .DIV_ITER(32)) dut (
    .clk(clk), .resetn(resetn), .alucontrol(alucontrol), .start(start),
    .flush(flush), .a(a), .b(b), .stall_o(stall_o), .done_o(done_o),
    .hi_o(hi_o), .lo_o(lo_o), .mf_data_o(mf_data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: cycles remaining in the op, pending result, HI/LO.
  logic [31:0] m_hi, m_lo, r_hi, r_lo;
  int          m_left = 0;
  logic        m_done = 1'b0;

  always @(posedge clk) begin
    longint sa, sb, q, r;
    logic [63:0] p;
    logic [31:0] ma, mb;
    if (!resetn) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_left <= 0; m_done <= 1'b0;
    end else if (flush) begin
      m_left <= 0; m_done <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      if (m_left == 1) begin
        m_hi <= r_hi; m_lo <= r_lo; m_done <= 1'b1;
      end
      m_left <= m_left - 1;
    end else if (start) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (alucontrol == MULTU_CONTROL) begin
        p = {32'd0, a} * {32'd0, b};
        r_hi <= p[63:32]; r_lo <= p[31:0]; m_left <= MUL_LAT;
      end else if (alucontrol == MULT_CONTROL) begin
        p = 64'(sa * sb);
        r_hi <= p[63:32]; r_lo <= p[31:0]; m_left <= MUL_LAT;
      end else if (alucontrol == DIVU_CONTROL) begin
        if (b == 32'd0) begin r_lo <= 32'hFFFFFFFF; r_hi <= a; end
        else begin r_lo <= a / b; r_hi <= a % b; end
        m_left <= 32;
      end else if (alucontrol == DIV_CONTROL) begin
        if (b == 32'd0) begin
          ma = a[31] ? (32'd0 - a) : a;
          mb = 32'hFFFFFFFF;
          r_lo <= a[31] ? (32'd0 - mb) : mb;
          r_hi <= a[31] ? (32'd0 - ma) : ma;
        end else begin
          q = sa / sb;
          r = sa % sb;
          r_lo <= q[31:0]; r_hi <= r[31:0];
        end
        m_left <= 32;
      end else if (alucontrol == MTHI_CONTROL) begin
        m_hi <= a;
      end else if (alucontrol == MTLO_CONTROL) begin
        m_lo <= a;
      end
    end
  end

  // Compare every cycle against the model, away from the active edge.
  always @(negedge clk) begin
    logic exp_stall;
    logic [31:0] exp_mf;
    if (chk_en) begin
      exp_stall = (m_left > 0) ||
                  (!m_done && start && !flush && is_muldiv(alucontrol));
      exp_mf = (alucontrol == MFHI_CONTROL) ? m_hi :
               (alucontrol == MFLO_CONTROL) ? m_lo : 32'd0;
      check("model stall_o", 64'(stall_o), 64'(exp_stall));
      check("model done_o", 64'(done_o), 64'(m_done));
      check("model hi_o", 64'(hi_o), 64'(m_hi));
      check("model lo_o", 64'(lo_o), 64'(m_lo));
      check("model mf_data_o", 64'(mf_data_o), 64'(exp_mf));
    end
  end

  task automatic run_op(input string nm, input logic [5:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input int exp_stall,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    n = 0;
    @(posedge clk); #1;
    alucontrol = op; start = 1'b1; flush = 1'b0; a = av; b = bv;
    @(negedge clk);
    while (stall_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({nm, " stall cycles"}, 64'(n), 64'(exp_stall));
    check({nm, " done"}, 64'(done_o), 64'd1);
    check({nm, " hi"}, 64'(hi_o), 64'(exp_hi));
    check({nm, " lo"}, 64'(lo_o), 64'(exp_lo));
    @(posedge clk); #1;
    start = 1'b0; alucontrol = 6'd0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [9];
    ops = '{MULT_CONTROL, MULTU_CONTROL, DIV_CONTROL, DIVU_CONTROL, MTHI_CONTROL,
            MTLO_CONTROL, MFHI_CONTROL, MFLO_CONTROL, 6'h3F};

    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    #1 resetn = 1'b1;
    @(negedge clk);
    check("reset hi", 64'(hi_o), 64'd0);
    check("reset lo", 64'(lo_o), 64'd0);
    check("reset stall", 64'(stall_o), 64'd0);

    run_op("MULTU max", MULTU_CONTROL, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 32'hFFFFFFFE, 32'h00000001);
    run_op("MULT -3*7", MULT_CONTROL, 32'hFFFFFFFD, 32'd7, 3, 32'hFFFFFFFF, 32'hFFFFFFEB);
    alucontrol = MFLO_CONTROL;
    @(negedge clk);
    check("MFLO read", 64'(mf_data_o), 64'hFFFFFFEB);
    run_op("DIV -7/2", DIV_CONTROL, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("DIVU 100/0", DIVU_CONTROL, 32'd100, 32'd0, 33, 32'h00000064, 32'hFFFFFFFF);
    run_op("DIV min/-1", DIV_CONTROL, 32'h80000000, 32'hFFFFFFFF, 33, 32'd0, 32'h80000000);

    // MTHI, then a DIV cancelled by flush in its 10th DIV cycle.
    @(posedge clk); #1;
    alucontrol = MTHI_CONTROL; a = 32'h11; start = 1'b1;
    @(negedge clk);
    check("MTHI no stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    alucontrol = DIV_CONTROL; a = 32'd50; b = 32'd3;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0; alucontrol = MTHI_CONTROL; a = 32'h1234; start = 1'b1;
    @(negedge clk);
    check("flush stall", 64'(stall_o), 64'd0);
    check("flush done", 64'(done_o), 64'd0);
    check("flush hi kept", 64'(hi_o), 64'h11);
    @(posedge clk); #1;
    start = 1'b0; alucontrol = 6'd0;
    @(negedge clk);
    check("MTHI write", 64'(hi_o), 64'h1234);

    // Reset in DIV cycle 5.
    @(posedge clk); #1;
    alucontrol = DIV_CONTROL; a = 32'd1000; b = 32'd7; start = 1'b1;
    repeat (5) @(posedge clk);
    #1 resetn = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("midop reset stall", 64'(stall_o), 64'd0);
    check("midop reset hi", 64'(hi_o), 64'd0);
    check("midop reset lo", 64'(lo_o), 64'd0);
    run_op("MULTU 2*3", MULTU_CONTROL, 32'd2, 32'd3, 3, 32'd0, 32'd6);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      resetn     = ($urandom_range(0, 499) != 0);
      flush      = ($urandom_range(0, 39) == 0);
      start      = ($urandom_range(0, 1) == 1);
      alucontrol = ops[$urandom_range(0, 8)];
      a          = pick_operand();
      b          = pick_operand();
    end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0; resetn = 1'b1;
    @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
